// File: rtl/soc_system_avalon_st_adapter_symbol_serializer_0.sv
// ---------------------------------------------------------------------------
// soc_system_avalon_st_adapter_symbol_serializer_0
//
// Purpose:
//   Downstream stage of the timing-adapter FIFO in the Avalon-ST adapter
//   chain. Each packed FIFO word {sop, eop, payload} is broken into
//   SYMBOLS_PER_WORD symbols, which are emitted one per beat, most-significant
//   symbol first. sop is placed on the word's first symbol and eop on its
//   last. A framing tracker raises a sticky protocol_error when packets are
//   malformed. Words are forwarded even when they are malformed.
//
// Ports:
//   clk               - single clock, all logic on the rising edge
//   reset             - synchronous active-high reset
//   in_ready          - sink ready (drives FIFO out_ready)
//   in_valid          - sink valid (from FIFO out_valid)
//   in_data           - [IN_WIDTH-1]=sop, [IN_WIDTH-2]=eop, rest = payload
//   out_ready         - downstream ready (ready latency 0)
//   out_valid         - source valid
//   out_data          - current symbol
//   out_startofpacket - first symbol of a packet
//   out_endofpacket   - last symbol of a packet
//   protocol_error    - sticky framing-error flag
//   clear_error       - synchronous clear of protocol_error
// ---------------------------------------------------------------------------
module soc_system_avalon_st_adapter_symbol_serializer_0 #(
  parameter int SYMBOLS_PER_WORD = 3,
  parameter int SYMBOL_WIDTH     = 8,
  parameter int IN_WIDTH         = SYMBOLS_PER_WORD * SYMBOL_WIDTH + 2,
  parameter int IDX_WIDTH        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_ready,
  input  logic                    in_valid,
  input  logic [IN_WIDTH-1:0]     in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic                    protocol_error,
  input  logic                    clear_error
);

  localparam int PAYLOAD_WIDTH = SYMBOLS_PER_WORD * SYMBOL_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SYMBOLS_PER_WORD - 1);

  // Two-state machine: IDLE = nothing held, SHIFT = a word is being emitted.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]               state;
  logic [IDX_WIDTH-1:0]     idx;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     held_sop;
  logic                     held_eop;
  logic                     in_packet;
  logic                     error_flag;

  logic                     hold_valid;
  logic                     last_symbol;
  logic                     accept;
  logic                     beat;
  logic                     word_sop;
  logic                     word_eop;
  logic                     frame_error;
  logic [PAYLOAD_WIDTH-1:0] shifted;

  assign hold_valid  = (state == SHIFT);
  assign last_symbol = (idx == LAST_IDX);

  // in_ready looks straight through to out_ready on the last symbol so that a
  // new word can be loaded in the same cycle the old one finishes (no bubble).
  assign in_ready  = !reset && (!hold_valid || (out_ready && last_symbol));
  assign out_valid = !reset && hold_valid;

  assign accept = in_valid && in_ready;
  assign beat   = out_valid && out_ready;

  assign word_sop = in_data[IN_WIDTH-1];
  assign word_eop = in_data[IN_WIDTH-2];

  // A word must open a packet exactly when no packet is currently open.
  assign frame_error = word_sop ? in_packet : !in_packet;

  // Shift the selected symbol to the top of the payload. idx counts from the
  // most-significant symbol, so symbol idx ends up in the top SYMBOL_WIDTH bits.
  assign shifted = payload << (SYMBOL_WIDTH * int'(idx));

  // Output decode; everything is forced low when nothing valid is presented.
  always_comb begin
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    if (out_valid) begin
      out_data          = shifted[PAYLOAD_WIDTH-1 -: SYMBOL_WIDTH];
      out_startofpacket = held_sop && (idx == '0);
      out_endofpacket   = held_eop && last_symbol;
    end else begin
      out_data          = '0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
    end
  end

  // Holding register: captures payload and framing bits on every accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      payload  <= '0;
      held_sop <= 1'b0;
      held_eop <= 1'b0;
    end else if (accept) begin
      payload  <= in_data[PAYLOAD_WIDTH-1:0];
      held_sop <= word_sop;
      held_eop <= word_eop;
    end
  end

  // Control: state and symbol index. An accept always restarts at symbol 0;
  // it can only coincide with a beat when the last symbol is leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      idx   <= '0;
    end else if (beat) begin
      if (last_symbol) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Framing tracker and sticky error flag; a fresh error beats clear_error.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_packet  <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      if (accept) begin
        in_packet <= !word_eop;
      end
      if (accept && frame_error) begin
        error_flag <= 1'b1;
      end else if (clear_error) begin
        error_flag <= 1'b0;
      end
    end
  end

  assign protocol_error = error_flag;

endmodule

// File: tb/tb_soc_system_avalon_st_adapter_symbol_serializer_0.sv
module tb_soc_system_avalon_st_adapter_symbol_serializer_0;

  logic        clk;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [25:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic        protocol_error;
  logic        clear_error;

  soc_system_avalon_st_adapter_symbol_serializer_0 dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .protocol_error    (protocol_error),
    .clear_error       (clear_error)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } sym_t;

  sym_t q[$];          // expected symbols still owed by the DUT
  int   tests = 0;
  int   fails = 0;
  int   accepts = 0;
  int   cyc = 0;
  int   first_beat = -1;
  int   last_beat = 0;
  int   nbeats = 0;
  int   mode = 0;      // out_ready pattern: 0 always, 1 = 1,0,0 repeating, 2 random
  int   pat = 0;
  logic m_in_packet = 1'b0;
  logic m_err = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_ready driver
  always @(negedge clk) begin
    pat++;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((pat % 3) == 0);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor / scoreboard: samples just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (reset) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        q.delete();
        m_in_packet = 1'b0;
        m_err = 1'b0;
      end else begin
        logic exp_valid;
        logic exp_ready;
        logic acc;
        logic bad;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("protocol_error", 32'(protocol_error), 32'(m_err));
        if (out_valid && q.size() != 0) begin
          chk("out_data", 32'(out_data), 32'(q[0].d));
          chk("out_sop", 32'(out_startofpacket), 32'(q[0].s));
          chk("out_eop", 32'(out_endofpacket), 32'(q[0].e));
          if (out_ready) begin
            void'(q.pop_front());
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            nbeats++;
          end
        end
        acc = in_valid && in_ready;
        bad = 1'b0;
        if (acc) begin
          for (int i = 0; i < 3; i++) begin
            sym_t s;
            s.d = in_data[23 - 8*i -: 8];
            s.s = in_data[25] && (i == 0);
            s.e = in_data[24] && (i == 2);
            q.push_back(s);
          end
          bad = in_data[25] ? m_in_packet : !m_in_packet;
          m_in_packet = !in_data[24];
          accepts++;
        end
        if (acc && bad) m_err = 1'b1;
        else if (clear_error) m_err = 1'b0;
      end
    end
  end

  task automatic send(input logic [25:0] w);
    int start;
    start = accepts;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 100 && accepts == start; k++) @(negedge clk);
    chk("send_accepted", 32'(accepts - start), 32'd1);
    in_valid = 1'b0;
    in_data  = 26'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_beats();
    first_beat = -1;
    nbeats = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 26'd0;
    clear_error = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single-word packet A1 B2 C3
    clear_beats();
    send(26'h3A1B2C3);
    drain();
    chk("single_beats", 32'(nbeats), 32'd3);
    chk("single_span", 32'(last_beat - first_beat), 32'd2);

    // Streaming 4-word packet without bubbles
    clear_beats();
    send(26'h2010203);
    send(26'h0040506);
    send(26'h0070809);
    send(26'h10A0B0C);
    drain();
    chk("stream_beats", 32'(nbeats), 32'd12);
    chk("stream_span", 32'(last_beat - first_beat), 32'd11);

    // Backpressure 1,0,0 pattern
    mode = 1;
    clear_beats();
    send(26'h2010203);
    send(26'h0040506);
    send(26'h0070809);
    send(26'h10A0B0C);
    drain();
    chk("bp_beats", 32'(nbeats), 32'd12);
    mode = 0;
    @(negedge clk);

    // Framing error: two sops without eop
    send(26'h2111111);
    send(26'h2222222);
    drain();
    chk("err_set", 32'(protocol_error), 32'd1);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(protocol_error), 32'd0);
    send(26'h1333333);
    drain();

    // Reset mid-word
    send(26'h3DDEEFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_beats();
    send(26'h3123456);
    drain();
    chk("post_reset_beats", 32'(nbeats), 32'd3);

    // Random well-formed packets with random valid gaps and out_ready
    mode = 2;
    begin
      int t0;
      t0 = cyc;
      while (cyc - t0 < 200) begin
        int len;
        len = $urandom_range(1, 4);
        for (int w = 0; w < len; w++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            in_data = 26'($urandom);
            @(negedge clk);
          end
          send({(w == 0), (w == len - 1), 24'($urandom)});
        end
      end
    end
    mode = 0;
    drain();
    chk("random_no_error", 32'(protocol_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_system_avalon_st_adapter_symbol_serializer_0.md
Name: soc_system_avalon_st_adapter_symbol_serializer_0

Overview:
- Downstream stage of the 26-bit timing-adapter FIFO in the Avalon-ST adapter chain.
- Consumes packed FIFO words {sop, eop, payload[23:0]} and emits one 8-bit symbol per beat, most-significant symbol first, with Avalon-ST sop/eop framing.
- Both sides use ready latency 0.
- Also tracks packet framing and raises a sticky protocol-error flag on malformed input.

Parameters:
- SYMBOLS_PER_WORD, 3, symbols carried in each input word (≥2).
- SYMBOL_WIDTH, 8, bits per output symbol.
- IN_WIDTH, SYMBOLS_PER_WORD*SYMBOL_WIDTH+2 (26), input word width. Derived; do not override independently.
- IDX_WIDTH, 2, width of the symbol index counter; must satisfy 2**IDX_WIDTH ≥ SYMBOLS_PER_WORD.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_ready  out  1  sink ready (to FIFO out_ready).
- in_valid  in  1  sink valid (from FIFO out_valid).
- in_data  in  IN_WIDTH  [25]=sop, [24]=eop, [23:0]=payload; symbol 0 = [23:16].
- out_ready  in  1  downstream ready.
- out_valid  out  1  source valid.
- out_data  out  SYMBOL_WIDTH  current symbol.
- out_startofpacket  out  1  first symbol of packet.
- out_endofpacket  out  1  last symbol of packet.
- protocol_error  out  1  sticky framing-error flag.
- clear_error  in  1  synchronous clear of protocol_error.

Behaviour:
- Reset, sampled at posedge while reset=1:
  - hold_valid←0, idx←0, in_packet←0, protocol_error←0.
  - During reset: in_ready=0, out_valid=0, out_startofpacket=0, out_endofpacket=0, out_data=0.
- Storage: holding register (payload, sop, eop), hold_valid, symbol index idx.
- State machine, two states:
  - IDLE (hold_valid=0): in_ready=1 (when not in reset).
  - SHIFT (hold_valid=1): out_valid=1.
- Output decode, combinational from the register:
  - out_data = payload symbol idx, MSB-first.
  - out_startofpacket = held_sop && idx==0.
  - out_endofpacket = held_eop && idx==SYMBOLS_PER_WORD-1.
- in_ready = !hold_valid || (out_ready && idx==SYMBOLS_PER_WORD-1). This is a combinational path from out_ready; this path is permitted.
- Accept, i.e. in_valid && in_ready at an edge: load register, hold_valid←1, idx←0. The word's symbol 0 appears on out_data in the following cycle. Latency is 1 cycle.
- Output beat, i.e. out_valid && out_ready:
  - idx<last: idx←idx+1.
  - idx==last and no accept this cycle: hold_valid←0, idx←0.
  - idx==last with a simultaneous accept: reload; idx←0, hold_valid stays 1. No bubble.
- Sustained throughput: 1 symbol/clk when in_valid and out_ready are continuously high. One word every SYMBOLS_PER_WORD clocks.
- Backpressure: with out_ready=0, register, idx and outputs hold stable; in_ready=0 in SHIFT.
- in_data is ignored when in_valid=0. out_data content is don't-care when out_valid=0, but must be driven (no X after reset).
- Framing tracker, updated on accept:
  - sop while in_packet=1 → protocol_error←1.
  - Word without sop while in_packet=0 → protocol_error←1.
  - in_packet←eop ? 0 : 1.
  - Words are always forwarded unchanged; errors are flagged, never dropped.
- Single-word packet (sop && eop): symbol 0 gets sop, last symbol gets eop, in_packet stays 0.
- clear_error=1 clears protocol_error at the next edge. A new error detected in the same cycle wins: the flag stays 1.
- Reset asserted mid-word discards the held word. The next accept restarts at idx 0, and no partial symbols are emitted after reset.

Test Plan:
- Reset then one word 0x3_A1B2C3 (sop=1, eop=1), out_ready=1:
  - out_data A1,B2,C3 on 3 consecutive cycles.
  - sop only on A1, eop only on C3.
  - out_valid falls the next cycle.
- Streaming: 4-word packet 0x2_010203, 0x0_040506, 0x0_070809, 0x1_0A0B0C, in_valid and out_ready held 1:
  - 12 consecutive out_valid cycles with data 01..0C and no bubble.
  - in_ready pulses high only on cycles where idx=2.
- Backpressure: during the same packet, toggle out_ready 1,0,0,1,...:
  - out_data/idx frozen while out_ready=0.
  - Order 01..0C preserved; no symbol duplicated or lost.
- Framing error: send 0x2_111111 then 0x2_222222 without an intervening eop → protocol_error=1 one cycle after the second accept. Both words are still output. Pulse clear_error → flag returns to 0.
- Reset mid-word: accept 0x3_DDEEFF, emit DD, assert reset for 1 cycle:
  - out_valid=0 and in_ready=0 during reset.
  - Next word 0x3_123456 emits 12,34,56 with correct sop/eop.
- Random: seeded random in_valid/out_ready for 200 cycles against a scoreboard model → all symbols match in order, and protocol_error stays 0 for well-formed packets.
